// File: rtl/display_decoder.sv
// ---------------------------------------------------------------------------
// display_decoder
//   Recovers the hex digits shown on a multiplexed 4-digit 7-segment display
//   by snooping its segment and digit-strobe lines.
//
//   A digit is accepted once its (segments, strobe) sample has been seen
//   identical for STABLE_CYCLES consecutive registered samples. Acceptance
//   happens exactly once per stable episode.
//
// Parameters
//   STABLE_CYCLES  identical samples needed to accept a digit (2..255)
//
// Configuration macro
//   DISPLAY_DECODER_ACTIVE_LOW_EN  defined: segments/digits are inverted at
//                                  the input (common-anode drive);
//                                  undefined: used as-is (active-high).
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        capture enable; low = no commits, outputs hold
//   segments  {a,b,c,d,e,f,g,dp}, 1 = lit
//   digits    strobe {D4,D3,D2,D1}; one-hot = active, 0 = blank
//   hexx      recovered hex, digit i at [4i+3:4i]
//   points    recovered decimal point per digit
//   mask      1 = digit last seen blank or unrecognized
//   valid     1 = digit committed at least once since reset
//   frame     one-cycle pulse when all four digits have been committed
//   bad       sticky: unrecognized pattern or multi-hot strobe seen
// ---------------------------------------------------------------------------
module display_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  segments,
  input  logic [3:0]  digits,
  output logic [15:0] hexx,
  output logic [3:0]  points,
  output logic [3:0]  mask,
  output logic [3:0]  valid,
  output logic        frame,
  output logic        bad
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [7:0] seg_in;
  logic [3:0] dig_in;

`ifdef DISPLAY_DECODER_ACTIVE_LOW_EN
  assign seg_in = ~segments;
  assign dig_in = ~digits;
`else
  assign seg_in = segments;
  assign dig_in = digits;
`endif

  // Sample register plus the previous sample it is compared against.
  logic [7:0] seg_reg, seg_prev_reg;
  logic [3:0] dig_reg, dig_prev_reg;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] track_reg, track_next;
  logic       frame_reg, frame_next;
  logic       bad_reg, bad_next;

  logic       one_hot, multi_hot, same, commit, known;
  logic [3:0] hex_val;
  logic [3:0] track_or;

  assign one_hot   = (dig_reg != 4'd0) && ((dig_reg & (dig_reg - 4'd1)) == 4'd0);
  assign multi_hot = (dig_reg != 4'd0) && !one_hot;
  assign same      = ({seg_reg, dig_reg} == {seg_prev_reg, dig_prev_reg});

  // Stability counter. Anything other than an enabled one-hot sample ends
  // the episode; a changed one-hot sample starts a new one at 1. The commit
  // fires only on the transition into STABLE_C, so a held digit commits once.
  always_comb begin
    cnt_next = 8'd0;
    commit   = 1'b0;
    if (en && one_hot) begin
      if (same)
        cnt_next = (cnt_reg >= STABLE_C) ? STABLE_C : cnt_reg + 8'd1;
      else
        cnt_next = 8'd1;
      commit = (cnt_next == STABLE_C) && (cnt_reg != STABLE_C);
    end
  end

  // Segment a..g decode.
  always_comb begin
    known   = 1'b1;
    hex_val = 4'h0;
    case (seg_reg[7:1])
      7'b1111110: hex_val = 4'h0;
      7'b0110000: hex_val = 4'h1;
      7'b1101101: hex_val = 4'h2;
      7'b1111001: hex_val = 4'h3;
      7'b0110011: hex_val = 4'h4;
      7'b1011011: hex_val = 4'h5;
      7'b1011111: hex_val = 4'h6;
      7'b1110000: hex_val = 4'h7;
      7'b1111111: hex_val = 4'h8;
      7'b1111011: hex_val = 4'h9;
      7'b1110111: hex_val = 4'hA;
      7'b0011111: hex_val = 4'hB;
      7'b1001110: hex_val = 4'hC;
      7'b0111101: hex_val = 4'hD;
      7'b1001111: hex_val = 4'hE;
      7'b1000111: hex_val = 4'hF;
      default:    known   = 1'b0;
    endcase
  end

  // Frame tracker: a frame completes on the commit that fills the last bit.
  always_comb begin
    track_next = track_reg;
    frame_next = 1'b0;
    track_or   = track_reg | dig_reg;
    if (commit) begin
      if (track_or == 4'hF) begin
        frame_next = 1'b1;
        track_next = 4'h0;
      end else begin
        track_next = track_or;
      end
    end
  end

  // A blank a..g pattern is a legitimate "digit off", not an error.
  assign bad_next = bad_reg
                  | (en & multi_hot)
                  | (commit & ~known & (seg_reg[7:1] != 7'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg      <= '0;
      dig_reg      <= '0;
      seg_prev_reg <= '0;
      dig_prev_reg <= '0;
      cnt_reg      <= '0;
      track_reg    <= '0;
      frame_reg    <= 1'b0;
      bad_reg      <= 1'b0;
    end else begin
      seg_reg      <= seg_in;
      dig_reg      <= dig_in;
      seg_prev_reg <= seg_reg;
      dig_prev_reg <= dig_reg;
      cnt_reg      <= cnt_next;
      track_reg    <= track_next;
      frame_reg    <= frame_next;
      bad_reg      <= bad_next;
    end
  end

  // Per-digit result registers.
  logic [3:0] nib_reg   [4];
  logic       pt_reg    [4];
  logic       mask_reg  [4];
  logic       valid_reg [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    always_ff @(posedge clk) begin
      if (rst) begin
        nib_reg[gi]   <= 4'h0;
        pt_reg[gi]    <= 1'b0;
        mask_reg[gi]  <= 1'b0;
        valid_reg[gi] <= 1'b0;
      end else if (commit && dig_reg[gi]) begin
        pt_reg[gi]    <= seg_reg[0];
        valid_reg[gi] <= 1'b1;
        mask_reg[gi]  <= ~known;
        if (known)
          nib_reg[gi] <= hex_val;
      end
    end

    assign hexx[4*gi +: 4] = nib_reg[gi];
    assign points[gi]      = pt_reg[gi];
    assign mask[gi]        = mask_reg[gi];
    assign valid[gi]       = valid_reg[gi];
  end

  assign frame = frame_reg;
  assign bad   = bad_reg;

endmodule

// File: tb/tb_display_decoder.sv
// ---------------------------------------------------------------------------
// tb_display_decoder
//   Self-checking bench for display_decoder: directed scenarios followed by
//   randomized display traffic, all compared every cycle against a
//   run-length reference model of the acceptance rules.
// ---------------------------------------------------------------------------
module tb_display_decoder;

  localparam int STABLE = 4;

`ifdef DISPLAY_DECODER_ACTIVE_LOW_EN
  localparam logic [7:0] INV_S = 8'hFF;
  localparam logic [3:0] INV_D = 4'hF;
`else
  localparam logic [7:0] INV_S = 8'h00;
  localparam logic [3:0] INV_D = 4'h0;
`endif

  localparam logic [6:0] PAT_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  l_seg;   // logical (active-high) stimulus
  logic [3:0]  l_dig;
  logic [7:0]  segments;
  logic [3:0]  digits;
  logic [15:0] hexx;
  logic [3:0]  points, mask, valid;
  logic        frame, bad;

  assign segments = l_seg ^ INV_S;
  assign digits   = l_dig ^ INV_D;

  always #5 clk = ~clk;

  display_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .en(en), .segments(segments), .digits(digits),
    .hexx(hexx), .points(points), .mask(mask), .valid(valid),
    .frame(frame), .bad(bad)
  );

  int n_total = 0;
  int n_bad   = 0;
  int frame_seen = 0;

  // Reference model state.
  logic [3:0]  m_hex [4];
  logic [3:0]  m_pt, m_mask, m_valid, m_track;
  logic        m_frame, m_bad;
  logic [11:0] m_sample;     // sample seen by the decoder at the next edge
  logic [11:0] run_val;
  int          run_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
    m_pt = 0; m_mask = 0; m_valid = 0; m_track = 0;
    m_frame = 0; m_bad = 0; m_sample = 0; run_val = 0; run_len = 0;
  endtask

  task automatic model_commit(input logic [7:0] s, input logic [3:0] d);
    int idx;
    bit found;
    logic [3:0] v;
    idx = 0; found = 0; v = 0;
    for (int i = 0; i < 4; i++) if (d[i]) idx = i;
    for (int k = 0; k < 16; k++) if (PAT_TAB[k] == s[7:1]) begin found = 1; v = 4'(k); end
    if (found) begin
      m_hex[idx]  = v;
      m_mask[idx] = 1'b0;
    end else begin
      m_mask[idx] = 1'b1;
      if (s[7:1] != 7'd0) m_bad = 1'b1;
    end
    m_pt[idx]    = s[0];
    m_valid[idx] = 1'b1;
    m_track[idx] = 1'b1;
    if (m_track == 4'hF) begin
      m_frame = 1'b1;
      m_track = 4'h0;
    end
  endtask

  // Acceptance = a run of STABLE consecutive enabled edges that all see the
  // same one-hot sample; the commit happens on the edge the run reaches it.
  task automatic model_edge(input logic r, input logic e, input logic [7:0] s, input logic [3:0] d);
    logic [3:0] sd;
    if (r) begin
      model_reset();
    end else begin
      sd = m_sample[3:0];
      m_frame = 1'b0;
      if (!e) begin
        run_len = 0;
      end else if ($countones(sd) > 1) begin
        m_bad = 1'b1;
        run_len = 0;
      end else if (sd == 4'd0) begin
        run_len = 0;
      end else begin
        if (run_len > 0 && m_sample == run_val) begin
          if (run_len <= STABLE) run_len++;
        end else begin
          run_len = 1;
          run_val = m_sample;
        end
        if (run_len == STABLE) model_commit(m_sample[11:4], sd);
      end
      m_sample = {s, d};
    end
  endtask

  task automatic step();
    logic r, e;
    logic [7:0] s;
    logic [3:0] d;
    r = rst; e = en; s = l_seg; d = l_dig;
    @(posedge clk);
    model_edge(r, e, s, d);
    #1;
    check("hexx",   hexx,   {m_hex[3], m_hex[2], m_hex[1], m_hex[0]});
    check("points", points, m_pt);
    check("mask",   mask,   m_mask);
    check("valid",  valid,  m_valid);
    check("frame",  frame,  m_frame);
    check("bad",    bad,    m_bad);
    if (frame) frame_seen++;
  endtask

  task automatic hold(input int n, input logic [3:0] d, input logic [7:0] s);
    l_dig = d;
    l_seg = s;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    l_dig = 0; l_seg = 0;
    step(); step();
    rst = 1'b0;
  endtask

  logic [3:0] d29 [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [7:0] s29 [4] = '{8'h9C,   8'h8E,   8'h60,   8'hFE};

  initial begin
    int kind, len;
    logic [3:0] d;
    logic [7:0] s;

    model_reset();
    rst = 1'b1; en = 1'b1; l_seg = 0; l_dig = 0;
    step(); step();
    check("rst_hexx",  hexx,  0);
    check("rst_valid", valid, 0);
    check("rst_mask",  mask,  0);
    check("rst_bad",   bad,   0);
    rst = 1'b0;

    // Single digit '3' on D1: commit on the 5th edge, then hold.
    l_dig = 4'b0001; l_seg = 8'hF2;
    repeat (4) step();
    check("d1_valid_before", valid, 4'b0000);
    step();
    check("d1_hex",   hexx[3:0], 4'h3);
    check("d1_point", points[0], 1'b0);
    check("d1_mask",  mask[0],   1'b0);
    check("d1_valid", valid,     4'b0001);
    repeat (3) step();
    check("d1_held_valid", valid, 4'b0001);

    // Full frame C,F,1,8.
    do_reset();
    frame_seen = 0;
    for (int i = 0; i < 4; i++) begin
      hold(6, d29[i], s29[i]);
      hold(2, 4'b0000, 8'h00);
    end
    check("frame_count", frame_seen, 1);
    check("frame_hexx",  hexx,  16'hFC81);
    check("frame_valid", valid, 4'hF);

    // Blank pattern with dp on D2.
    hold(6, 4'b0010, 8'h01);
    check("blank_mask",  mask[1],   1'b1);
    check("blank_point", points[1], 1'b1);
    check("blank_nib",   hexx[7:4], 4'h8);
    check("blank_bad",   bad,       1'b0);

    // Multi-hot strobe, then an unrecognized pattern.
    hold(10, 4'b0011, 8'h60);
    check("multi_bad",   bad,   1'b1);
    check("multi_valid", valid, 4'hF);
    hold(2, 4'b0000, 8'h00);
    hold(6, 4'b0001, 8'h40);
    check("unrec_mask", mask[0], 1'b1);
    check("unrec_bad",  bad,     1'b1);

    // Toggling pattern never commits; reset mid-episode discards it.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      hold(2, 4'b0001, 8'hFC);
      hold(2, 4'b0001, 8'h60);
    end
    check("toggle_valid", valid, 4'h0);
    hold(2, 4'b0000, 8'h00);
    hold(3, 4'b0001, 8'hF2);
    rst = 1'b1;
    step();
    check("midrst_valid", valid, 4'h0);
    check("midrst_hexx",  hexx,  0);
    rst = 1'b0;
    repeat (4) step();
    check("postrst_valid_early", valid, 4'h0);
    step();
    check("postrst_valid", valid,     4'b0001);
    check("postrst_hex",   hexx[3:0], 4'h3);

    // Randomized traffic.
    for (int blk = 0; blk < 600; blk++) begin
      kind = $urandom_range(0, 99);
      len  = $urandom_range(1, 8);
      d = 4'(1 << $urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0:       s = {7'd0, 1'($urandom_range(0, 1))};
        1:       s = 8'($urandom);
        default: s = {PAT_TAB[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
      endcase
      if (kind < 3) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else if (kind < 8) begin
        en = 1'b0; hold($urandom_range(1, 4), d, s); en = 1'b1;
      end else if (kind < 13) begin
        hold(len, 4'($urandom_range(3, 15)) | 4'b0011, s);
      end else if (kind < 28) begin
        hold($urandom_range(1, 3), 4'b0000, 8'h00);
      end else begin
        hold(len, d, s);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/display_decoder.md
DISPLAY_DECODER -- requirements
Module: display_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4 (legal 2..255); consecutive identical samples required to accept a digit.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  capture enable; low = no commits, outputs hold.
REQ-005 segments  input  8  {a,b,c,d,e,f,g,dp}, 1 = lit.
REQ-006 digits  input  4  digit strobe {D4,D3,D2,D1}; one-hot = digit active, 0 = blank interval.
REQ-007 hexx  output  16  recovered hex; digit i at [4i+3:4i].
REQ-008 points  output  4  recovered dp per digit.
REQ-009 mask  output  4  1 = digit last seen blank or unrecognized.
REQ-010 valid  output  4  1 = digit committed at least once since reset.
REQ-011 frame  output  1  one-cycle pulse on completion of a full four-digit frame.
REQ-012 bad  output  1  sticky: unrecognized pattern or multi-hot strobe seen.

Function
REQ-013 segments and digits SHALL be registered once per clk (sample register) before any comparison.
REQ-014 Episode: sample equal to the previous sample with one-hot digits increments a stability counter, saturating at STABLE_CYCLES.
REQ-015 Sample differing from the previous, digits == 0, or en low SHALL clear the counter to 1 (one-hot digits) or 0 (otherwise).
REQ-016 Commit occurs exactly once per episode, when the counter reaches STABLE_CYCLES; outputs update on that edge, i.e. STABLE_CYCLES+1 edges after inputs settle.
REQ-017 Decode a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-018 On commit of a recognized pattern: nibble written, mask[i]=0, points[i]=dp, valid[i]=1.
REQ-019 On commit of a..g == 0000000: mask[i]=1, nibble held, points[i]=dp, valid[i]=1.
REQ-020 On commit of any other pattern: mask[i]=1, nibble held, points[i]=dp, valid[i]=1, bad=1.
REQ-021 Multi-hot digits sample SHALL set bad and clear the counter; no commit.
REQ-022 Per-frame tracker bit i set on commit of digit i; when a commit makes all four set, frame pulses on that edge and tracker clears to 0000.
REQ-023 Re-committing an already-set tracker digit SHALL NOT pulse frame.
REQ-024 en low SHALL also hold tracker bits; bad, valid remain sticky.

Reset
REQ-025 rst high at a clk edge SHALL clear hexx, points, mask, valid, frame, bad, sample register, counter and tracker to 0, overriding all other activity.
REQ-026 rst mid-episode SHALL discard the episode; a new commit requires STABLE_CYCLES fresh identical samples after rst deasserts.

Configuration
REQ-027 Macro DISPLAY_DECODER_ACTIVE_LOW_EN defined: segments and digits inverted at input before the sample register (common-anode drive); undefined: used as-is, active-high.

Verification
REQ-028 digits=0001, segments=11110010 held 5 edges, STABLE_CYCLES=4 -> on 5th edge hexx[3:0]=3, points[0]=0, mask[0]=0, valid=0001; no further update while held.
REQ-029 Cycle 0100/C, 1000/F, 0001/1, 0010/8 each 6 cycles with 2-cycle blanks -> frame pulses once at 8 commit, hexx=16'hFC81, valid=1111.
REQ-030 digits=0010, segments=00000001 stable 6 cycles -> mask[1]=1, points[1]=1, hexx[7:4] unchanged, bad=0.
REQ-031 digits=0011 for 10 cycles -> bad=1, no commit, valid unchanged; segments=01000000 on 0001 -> bad=1, mask[0]=1.
REQ-032 Pattern toggling every 2 cycles with STABLE_CYCLES=4 -> no commit; rst asserted after 3 stable samples -> all outputs 0, commit 5 edges after rst release.
REQ-033 With DISPLAY_DECODER_ACTIVE_LOW_EN: digits=1110, segments=00001101 -> hexx[3:0]=3 after 5 edges.
